// File: rtl/case_stream_pkg.sv
// Shared types and constants for the case_stream_mux stream selector.
package case_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOCK_CH,
    LOCK_FILL
  } state_e;

  localparam int unsigned STAT_W = 16;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry valid/ready buffer; registered output, accepts a push on a full
// buffer when the head is popped in the same cycle.
module stream_skid_buf
  import case_stream_pkg::*;
#(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_data_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             push, pop;

  assign pop  = (cnt_q != 2'd0) && m_ready_i;
  assign push = s_valid_i && ((cnt_q != 2'd2) || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // On full push+pop the write slot equals the head being popped, so the
  // overwrite is safe and nothing is lost or duplicated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= s_data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign m_data_o  = mem_q[rd_ptr_q];
  assign m_valid_o = (cnt_q != 2'd0);
  assign s_ready_o = (cnt_q != 2'd2);

endmodule

// File: rtl/case_stream_mux.sv
// Packet-locked stream selector: routes one input channel or a fill packet
// through a skid buffer. CASE_STREAM_MUX_STATS_EN adds the beat_count output.
module case_stream_mux
  import case_stream_pkg::*;
#(
  parameter int unsigned          DATA_W       = 8,
  parameter int unsigned          NUM_CH       = 4,
  parameter logic [DATA_W-1:0]    FILL_PATTERN = DATA_W'(8'hAA),
  parameter int unsigned          FILL_LEN     = 4,
  localparam int unsigned         SEL_W        = $clog2(NUM_CH+1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH-1:0]        in_last,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic                     locked,
  output logic [SEL_W-1:0]         cur_src
`ifdef CASE_STREAM_MUX_STATS_EN
  ,
  output logic [STAT_W-1:0]        beat_count
`endif
);

  localparam logic [7:0]       FILL_LAST = 8'(FILL_LEN - 1);
  localparam logic [SEL_W-1:0] SEL_FILL  = SEL_W'(NUM_CH);

  state_e           state_q;
  logic [SEL_W-1:0] cur_src_q;
  logic             locked_q;
  logic [7:0]       fill_cnt_q;

  logic [DATA_W-1:0] ch_data;
  logic              ch_valid, ch_last;
  logic              buf_ready, ch_acc, fill_push, fill_end;
  logic              push_valid;
  logic [DATA_W:0]   push_data, buf_out;

  always_comb begin
    ch_data  = '0;
    ch_valid = 1'b0;
    ch_last  = 1'b0;
    in_ready = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (cur_src_q == SEL_W'(k)) begin
        ch_data     = in_data[k*DATA_W +: DATA_W];
        ch_valid    = in_valid[k];
        ch_last     = in_last[k];
        in_ready[k] = (state_q == LOCK_CH) && buf_ready;
      end
    end
  end

  assign ch_acc     = (state_q == LOCK_CH) && ch_valid && buf_ready;
  assign fill_push  = (state_q == LOCK_FILL) && buf_ready;
  assign fill_end   = (fill_cnt_q == FILL_LAST);
  assign push_valid = ch_acc || fill_push;
  assign push_data  = fill_push ? {FILL_PATTERN, fill_end} : {ch_data, ch_last};

  // Lock decisions are made only in IDLE, so sel is ignored for the whole
  // packet and a new lock always costs one IDLE cycle after packet end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_src_q  <= '0;
      locked_q   <= 1'b0;
      fill_cnt_q <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel < SEL_FILL) begin
            cur_src_q <= sel;
            locked_q  <= 1'b1;
            state_q   <= LOCK_CH;
          end else if (sel == SEL_FILL) begin
            locked_q  <= 1'b1;
            state_q   <= LOCK_FILL;
          end
        end
        LOCK_CH: begin
          if (ch_acc && ch_last) begin
            locked_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        LOCK_FILL: begin
          if (fill_push) begin
            if (fill_end) begin
              fill_cnt_q <= 8'd0;
              locked_q   <= 1'b0;
              state_q    <= IDLE;
            end else begin
              fill_cnt_q <= fill_cnt_q + 8'd1;
            end
          end
        end
        default: begin
          locked_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  stream_skid_buf #(
    .WIDTH(DATA_W + 1)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data_i  (push_data),
    .s_valid_i (push_valid),
    .s_ready_o (buf_ready),
    .m_data_o  (buf_out),
    .m_valid_o (out_valid),
    .m_ready_i (out_ready)
  );

  assign out_data = buf_out[DATA_W:1];
  assign out_last = buf_out[0];
  assign locked   = locked_q;
  assign cur_src  = cur_src_q;

`ifdef CASE_STREAM_MUX_STATS_EN
  logic [STAT_W-1:0] beat_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
    end else if (out_valid && out_ready && (beat_cnt_q != '1)) begin
      beat_cnt_q <= beat_cnt_q + 1'b1;
    end
  end

  assign beat_count = beat_cnt_q;
`endif

endmodule

// File: tb/tb_case_stream_mux.sv
// Directed self-checking bench for case_stream_mux (DATA_W=8, NUM_CH=4, FILL_LEN=4).
module tb_case_stream_mux;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 3;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [SEL_W-1:0]         sel;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_last;
  logic [NUM_CH-1:0]        in_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_last;
  logic                     out_ready;
  logic                     locked;
  logic [SEL_W-1:0]         cur_src;
`ifdef CASE_STREAM_MUX_STATS_EN
  logic [15:0]              beat_count;
`endif

  int checks   = 0;
  int failures = 0;

  case_stream_mux #(
    .DATA_W      (8),
    .NUM_CH      (4),
    .FILL_PATTERN(8'hAA),
    .FILL_LEN    (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .locked    (locked),
    .cur_src   (cur_src)
`ifdef CASE_STREAM_MUX_STATS_EN
    ,
    .beat_count(beat_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic idle_inputs;
    sel      = 3'd7;
    in_data  = '0;
    in_valid = '0;
    in_last  = '0;
  endtask

  task automatic set_ch(input int ch, input logic [7:0] d, input logic l);
    in_data[ch*8 +: 8] = d;
    in_last[ch]        = l;
    in_valid[ch]       = 1'b1;
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
    checks++;
    if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
    checks++;
    if (in_ready !== 4'b0000) begin failures++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready); end
    checks++;
    if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked: got %b expected 0", locked); end
    checks++;
    if (cur_src !== 3'd0) begin failures++; $display("FAIL reset_cur_src: got %0d expected 0", cur_src); end
`ifdef CASE_STREAM_MUX_STATS_EN
    checks++;
    if (beat_count !== 16'h0000) begin failures++; $display("FAIL reset_beat_count: got %h expected 0000", beat_count); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_channel;
    logic [7:0] bd [3];
    bd[0] = 8'h11; bd[1] = 8'h22; bd[2] = 8'h33;
    sel = 3'd1;
    @(negedge clk);
    checks++;
    if ({locked, cur_src} !== {1'b1, 3'd1}) begin
      failures++; $display("FAIL ch_lock: got locked=%b cur_src=%0d expected locked=1 cur_src=1", locked, cur_src);
    end
    checks++;
    if (in_ready !== 4'b0010) begin failures++; $display("FAIL ch_in_ready: got %b expected 0010", in_ready); end
    sel = 3'd7;
    set_ch(1, bd[0], 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_data, out_last} !== {1'b1, bd[i], (i == 2)}) begin
        failures++;
        $display("FAIL ch_beat%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                 i, out_valid, out_data, out_last, bd[i], (i == 2));
      end
      if (i < 2) set_ch(1, bd[i+1], (i + 1 == 2));
      else       idle_inputs();
    end
    checks++;
    if (locked !== 1'b0) begin failures++; $display("FAIL ch_unlock: got %b expected 0", locked); end
    @(negedge clk);
    checks++;
    if ({out_valid, locked} !== 2'b00) begin
      failures++; $display("FAIL ch_after: got valid=%b locked=%b expected 0 0", out_valid, locked);
    end
  endtask

  task automatic test_fill;
    int nb = 0;
    sel = 3'd4;
    @(negedge clk);
    checks++;
    if (locked !== 1'b1) begin failures++; $display("FAIL fill_lock: got %b expected 1", locked); end
    sel = 3'd7;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) begin
        nb++;
        checks++;
        if ({out_data, out_last} !== {8'hAA, (nb == 4)}) begin
          failures++;
          $display("FAIL fill_beat%0d: got d=%h l=%b expected d=aa l=%b", nb, out_data, out_last, (nb == 4));
        end
      end
    end
    checks++;
    if (nb != 4) begin failures++; $display("FAIL fill_count: got %0d expected 4", nb); end
    checks++;
    if (locked !== 1'b0) begin failures++; $display("FAIL fill_unlock: got %b expected 0", locked); end
  endtask

  task automatic test_sel_switch;
    sel = 3'd0;
    @(negedge clk);
    checks++;
    if ({locked, cur_src} !== {1'b1, 3'd0}) begin
      failures++; $display("FAIL sw_lock: got locked=%b cur_src=%0d expected 1 0", locked, cur_src);
    end
    sel = 3'd2;
    set_ch(0, 8'hA0, 1'b0);
    set_ch(2, 8'hEE, 1'b1);
    checks++;
    if (in_ready !== 4'b0001) begin failures++; $display("FAIL sw_ready0: got %b expected 0001", in_ready); end
    @(negedge clk);
    checks++;
    if ({out_valid, out_data, out_last} !== {1'b1, 8'hA0, 1'b0}) begin
      failures++; $display("FAIL sw_beat0: got v=%b d=%h l=%b expected 1 a0 0", out_valid, out_data, out_last);
    end
    set_ch(0, 8'hA1, 1'b0);
    checks++;
    if ({in_ready, cur_src} !== {4'b0001, 3'd0}) begin
      failures++; $display("FAIL sw_ignore: got in_ready=%b cur_src=%0d expected 0001 0", in_ready, cur_src);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, out_data, out_last} !== {1'b1, 8'hA1, 1'b0}) begin
      failures++; $display("FAIL sw_beat1: got v=%b d=%h l=%b expected 1 a1 0", out_valid, out_data, out_last);
    end
    set_ch(0, 8'hA2, 1'b1);
    sel         = 3'd7;
    in_valid[2] = 1'b0;
    in_last[2]  = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, out_data, out_last, locked} !== {1'b1, 8'hA2, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL sw_beat2: got v=%b d=%h l=%b locked=%b expected 1 a2 1 0", out_valid, out_data, out_last, locked);
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL sw_no_extra: got %b expected 0", out_valid); end
  endtask

  task automatic test_backpressure;
    int tx = 0;
    int rx = 0;
    int stall_acc = 0;
    sel = 3'd3;
    @(negedge clk);
    checks++;
    if ({locked, cur_src} !== {1'b1, 3'd3}) begin
      failures++; $display("FAIL bp_lock: got locked=%b cur_src=%0d expected 1 3", locked, cur_src);
    end
    sel = 3'd7;
    for (int cyc = 0; cyc < 16; cyc++) begin
      out_ready = (cyc >= 5);
      if (tx < 4) set_ch(3, 8'(8'h31 + tx), (tx == 3));
      else begin in_valid = '0; in_last = '0; end
      #1;
      if (cyc >= 1 && cyc <= 4) begin
        checks++;
        if ({out_valid, out_data} !== {1'b1, 8'h31}) begin
          failures++; $display("FAIL bp_stall_head cyc%0d: got v=%b d=%h expected 1 31", cyc, out_valid, out_data);
        end
      end
      if (cyc >= 2 && cyc <= 5) begin
        checks++;
        if (in_ready[3] !== 1'b0) begin
          failures++; $display("FAIL bp_full_ready cyc%0d: got %b expected 0", cyc, in_ready[3]);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if ({out_data, out_last} !== {8'(8'h31 + rx), (rx == 3)}) begin
          failures++;
          $display("FAIL bp_rx%0d: got d=%h l=%b expected d=%h l=%b", rx, out_data, out_last, 8'(8'h31 + rx), (rx == 3));
        end
        rx++;
      end
      if (in_valid[3] && in_ready[3]) begin
        if (!out_ready) stall_acc++;
        tx++;
      end
      @(negedge clk);
    end
    idle_inputs();
    out_ready = 1'b1;
    checks++;
    if (stall_acc != 2) begin failures++; $display("FAIL bp_buffered: got %0d expected 2", stall_acc); end
    checks++;
    if (rx != 4) begin failures++; $display("FAIL bp_rx_count: got %0d expected 4", rx); end
    checks++;
    if (locked !== 1'b0) begin failures++; $display("FAIL bp_unlock: got %b expected 0", locked); end
  endtask

  task automatic test_reset_mid_fill;
    int nb = 0;
    sel       = 3'd4;
    out_ready = 1'b0;
    @(negedge clk);
    sel = 3'd7;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL rst_pre_valid: got %b expected 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_last, locked, in_ready} !== 7'b0) begin
      failures++;
      $display("FAIL rst_async: got v=%b l=%b locked=%b in_ready=%b expected all 0", out_valid, out_last, locked, in_ready);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    sel       = 3'd4;
    out_ready = 1'b1;
    @(negedge clk);
    sel = 3'd7;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (out_valid) begin
        nb++;
        checks++;
        if ({out_data, out_last} !== {8'hAA, (nb == 4)}) begin
          failures++;
          $display("FAIL rst_refill_beat%0d: got d=%h l=%b expected d=aa l=%b", nb, out_data, out_last, (nb == 4));
        end
      end
    end
    checks++;
    if (nb != 4) begin failures++; $display("FAIL rst_refill_count: got %0d expected 4", nb); end
  endtask

`ifdef CASE_STREAM_MUX_STATS_EN
  task automatic test_stats;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    sel       = 3'd0;
    set_ch(0, 8'h5A, 1'b0);
    @(negedge clk);
    sel = 3'd7;
    repeat (70010) @(negedge clk);
    checks++;
    if (beat_count !== 16'hFFFF) begin failures++; $display("FAIL stats_saturate: got %h expected ffff", beat_count); end
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_channel();
    test_fill();
    test_sel_switch();
    test_backpressure();
    test_reset_mid_fill();
`ifdef CASE_STREAM_MUX_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
